// File: rtl/vgpr_banked_regfile_sync_pkg.sv
// Shared definitions for the banked vector register file: sweep/run state
// encoding, read-port count and the wide-write mask legality check.
package vgpr_banked_regfile_sync_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  localparam int RD_PORTS = 3;

  // Legal masks are 0 or a run of ones starting at bit 0 (2**k-1).
  function automatic logic mask_legal(input logic [31:0] mask);
    return (mask & (mask + 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/vgpr_banked_regfile_sync_if.sv
// Request/response bundle of the banked vector register file.
// The slave side is the register file, the master side is the issue/writeback logic.
interface vgpr_banked_regfile_sync_if #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int NUM_BANKS = 4
);

  logic                          init_done;

  logic                          rd0_en;
  logic [ADDR_W-1:0]             rd0_addr;
  logic [NUM_BANKS*DATA_W-1:0]   rd0_data;
  logic                          rd0_valid;

  logic                          rd1_en;
  logic [ADDR_W-1:0]             rd1_addr;
  logic [DATA_W-1:0]             rd1_data;
  logic                          rd1_valid;

  logic                          rd2_en;
  logic [ADDR_W-1:0]             rd2_addr;
  logic [DATA_W-1:0]             rd2_data;
  logic                          rd2_valid;

  logic                          wr0_en;
  logic [ADDR_W-1:0]             wr0_addr;
  logic [DATA_W-1:0]             wr0_data;

  logic [NUM_BANKS-1:0]          wr1_mask;
  logic [ADDR_W-1:0]             wr1_addr;
  logic [NUM_BANKS*DATA_W-1:0]   wr1_data;

  modport master (
    input  init_done,
    output rd0_en, rd0_addr, input rd0_data, rd0_valid,
    output rd1_en, rd1_addr, input rd1_data, rd1_valid,
    output rd2_en, rd2_addr, input rd2_data, rd2_valid,
    output wr0_en, wr0_addr, wr0_data,
    output wr1_mask, wr1_addr, wr1_data
  );

  modport slave (
    output init_done,
    input  rd0_en, rd0_addr, output rd0_data, rd0_valid,
    input  rd1_en, rd1_addr, output rd1_data, rd1_valid,
    input  rd2_en, rd2_addr, output rd2_data, rd2_valid,
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_mask, wr1_addr, wr1_data
  );

endinterface

// File: rtl/vgpr_banked_regfile_sync_bank.sv
// One bank of the register file: 3 registered read ports, 2 write ports, port B wins.
// VGPR_RF_WRITE_BYPASS_EN selects write-first reads; otherwise reads are read-first.
module vgpr_banked_regfile_sync_bank
  import vgpr_banked_regfile_sync_pkg::*;
#(
  parameter int ROW_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [RD_PORTS-1:0]              rd_en,
  input  logic [RD_PORTS-1:0][ROW_W-1:0]   rd_row,
  output logic [RD_PORTS-1:0][DATA_W-1:0]  rd_data,
  input  logic                             wa_en,
  input  logic [ROW_W-1:0]                 wa_row,
  input  logic [DATA_W-1:0]                wa_data,
  input  logic                             wb_en,
  input  logic [ROW_W-1:0]                 wb_row,
  input  logic [DATA_W-1:0]                wb_data
);

  logic [DATA_W-1:0] mem [2**ROW_W];
  logic              wa_blocked;

  assign wa_blocked = wb_en && (wb_row == wa_row);

  always_ff @(posedge clk) begin
    if (wb_en) mem[wb_row] <= wb_data;
    if (wa_en && !wa_blocked) mem[wa_row] <= wa_data;
  end

  // Read registers hold their value between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      for (int p = 0; p < RD_PORTS; p++) begin
        if (rd_en[p]) begin
`ifdef VGPR_RF_WRITE_BYPASS_EN
          if (wb_en && wb_row == rd_row[p])      rd_data[p] <= wb_data;
          else if (wa_en && wa_row == rd_row[p]) rd_data[p] <= wa_data;
          else                                   rd_data[p] <= mem[rd_row[p]];
`else
          rd_data[p] <= mem[rd_row[p]];
`endif
        end
      end
    end
  end

endmodule

// File: rtl/vgpr_banked_regfile_sync.sv
// Word-interleaved banked vector register file with zero-init sweep, wide unaligned ports
// and wr1-wins collision handling. VGPR_RF_WRITE_BYPASS_EN selects write-first reads.
module vgpr_banked_regfile_sync
  import vgpr_banked_regfile_sync_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int NUM_BANKS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  vgpr_banked_regfile_sync_if.slave bus
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam logic [ROW_W-1:0] ROW_LAST = '1;

  rf_state_e         state, state_nx;
  logic [ROW_W-1:0]  cnt, cnt_nx;
  logic              sweep, run, mask_ok;
  logic              rd0_acc, rd1_acc, rd2_acc;
  logic              rd0_valid_q, rd1_valid_q, rd2_valid_q;
  logic [BANK_W-1:0] rd0_rot_q, rd1_bank_q, rd2_bank_q;
  logic [RD_PORTS-1:0][DATA_W-1:0] bank_rd [NUM_BANKS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == ROW_LAST) state_nx = ST_RUN;
      end
      ST_RUN:  state_nx = ST_RUN;
    endcase
  end

  assign sweep   = !rst && (state == ST_INIT);
  assign run     = !rst && (state == ST_RUN);
  assign mask_ok = mask_legal(32'(bus.wr1_mask));
  assign rd0_acc = run && bus.rd0_en;
  assign rd1_acc = run && bus.rd1_en;
  assign rd2_acc = run && bus.rd2_en;

  // Each bank serves the lane of the wide access whose word falls into it.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam logic [BANK_W-1:0] BIDX = BANK_W'(b);
    logic [BANK_W-1:0]              rd0_lane, wr1_lane;
    logic [ROW_W-1:0]               rd0_row, wr1_row;
    logic [RD_PORTS-1:0][ROW_W-1:0] rd_row;
    logic                           wa_en, wb_en;
    logic [ROW_W-1:0]               wa_row;
    logic [DATA_W-1:0]              wa_data, wb_data;

    assign rd0_lane = BIDX - bus.rd0_addr[BANK_W-1:0];
    assign wr1_lane = BIDX - bus.wr1_addr[BANK_W-1:0];
    assign rd0_row  = ROW_W'((bus.rd0_addr + ADDR_W'(rd0_lane)) >> BANK_W);
    assign wr1_row  = ROW_W'((bus.wr1_addr + ADDR_W'(wr1_lane)) >> BANK_W);
    assign rd_row   = {bus.rd2_addr[ADDR_W-1:BANK_W], bus.rd1_addr[ADDR_W-1:BANK_W], rd0_row};

    assign wa_en   = sweep || (run && bus.wr0_en && (bus.wr0_addr[BANK_W-1:0] == BIDX));
    assign wa_row  = sweep ? cnt : bus.wr0_addr[ADDR_W-1:BANK_W];
    assign wa_data = sweep ? '0 : bus.wr0_data;
    assign wb_en   = run && mask_ok && bus.wr1_mask[wr1_lane];
    assign wb_data = bus.wr1_data[wr1_lane*DATA_W +: DATA_W];

    vgpr_banked_regfile_sync_bank #(
      .ROW_W  (ROW_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .rd_en   ({rd2_acc, rd1_acc, rd0_acc}),
      .rd_row  (rd_row),
      .rd_data (bank_rd[b]),
      .wa_en   (wa_en),
      .wa_row  (wa_row),
      .wa_data (wa_data),
      .wb_en   (wb_en),
      .wb_row  (wr1_row),
      .wb_data (wb_data)
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_valid_q <= 1'b0;
      rd1_valid_q <= 1'b0;
      rd2_valid_q <= 1'b0;
      rd0_rot_q   <= '0;
      rd1_bank_q  <= '0;
      rd2_bank_q  <= '0;
    end else begin
      rd0_valid_q <= rd0_acc;
      rd1_valid_q <= rd1_acc;
      rd2_valid_q <= rd2_acc;
      if (rd0_acc) rd0_rot_q  <= bus.rd0_addr[BANK_W-1:0];
      if (rd1_acc) rd1_bank_q <= bus.rd1_addr[BANK_W-1:0];
      if (rd2_acc) rd2_bank_q <= bus.rd2_addr[BANK_W-1:0];
    end
  end

  // Lane i of the wide result sits in bank (base + i) mod NUM_BANKS.
  always_comb begin
    bus.rd0_data = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bus.rd0_data[i*DATA_W +: DATA_W] = bank_rd[rd0_rot_q + BANK_W'(i)][0];
    end
  end

  assign bus.rd1_data  = bank_rd[rd1_bank_q][1];
  assign bus.rd2_data  = bank_rd[rd2_bank_q][2];
  assign bus.rd0_valid = rd0_valid_q;
  assign bus.rd1_valid = rd1_valid_q;
  assign bus.rd2_valid = rd2_valid_q;
  assign bus.init_done = (state == ST_RUN);

  a_wr1_mask_contiguous: assert property (@(posedge clk) disable iff (rst)
    (state == ST_RUN) |-> mask_ok);

endmodule

// File: tb/tb_vgpr_banked_regfile_sync.sv
// Self-checking bench for vgpr_banked_regfile_sync: directed vector table, hand-written
// reset/sweep sequences and randomized traffic against a word-array reference model.
module tb_vgpr_banked_regfile_sync;

`ifdef VGPR_RF_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [31:0] WA = 32'hAAAA0001, WB = 32'hBBBB0002;
  localparam logic [31:0] WC = 32'hCCCC0003, WD = 32'hDDDD0004;
  localparam logic [31:0] X5 = 32'h55550005, X6 = 32'h66660006;

  typedef struct packed {
    logic         wr0_en;
    logic [9:0]   wr0_addr;
    logic [31:0]  wr0_data;
    logic [3:0]   wr1_mask;
    logic [9:0]   wr1_addr;
    logic [127:0] wr1_data;
    logic         rd0_en;
    logic [9:0]   rd0_addr;
    logic         rd1_en;
    logic [9:0]   rd1_addr;
    logic         rd2_en;
    logic [9:0]   rd2_addr;
    logic [127:0] exp_rd0;
    logic [31:0]  exp_rd1;
    logic [31:0]  exp_rd2;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] model_mem [1024];
  vec_t vecs [10];

  vgpr_banked_regfile_sync_if #(.ADDR_W(10), .DATA_W(32), .NUM_BANKS(4)) bus ();

  vgpr_banked_regfile_sync #(.ADDR_W(10), .DATA_W(32), .NUM_BANKS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd0_en = 1'b0; bus.rd0_addr = '0;
    bus.rd1_en = 1'b0; bus.rd1_addr = '0;
    bus.rd2_en = 1'b0; bus.rd2_addr = '0;
    bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_mask = '0; bus.wr1_addr = '0; bus.wr1_data = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    bus.wr0_en = v.wr0_en; bus.wr0_addr = v.wr0_addr; bus.wr0_data = v.wr0_data;
    bus.wr1_mask = v.wr1_mask; bus.wr1_addr = v.wr1_addr; bus.wr1_data = v.wr1_data;
    bus.rd0_en = v.rd0_en; bus.rd0_addr = v.rd0_addr;
    bus.rd1_en = v.rd1_en; bus.rd1_addr = v.rd1_addr;
    bus.rd2_en = v.rd2_en; bus.rd2_addr = v.rd2_addr;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
  endtask

  // wr0 lands first, so a colliding wr1 word overwrites it.
  task automatic model_write(input vec_t v);
    logic [9:0] a;
    if (v.wr0_en) model_mem[v.wr0_addr] = v.wr0_data;
    for (int i = 0; i < 4; i++) begin
      a = v.wr1_addr + 10'(i);
      if (v.wr1_mask[i]) model_mem[a] = v.wr1_data[i*32 +: 32];
    end
  endtask

  function automatic logic [127:0] model_wide(input logic [9:0] base);
    logic [127:0] r;
    logic [9:0]   a;
    for (int i = 0; i < 4; i++) begin
      a = base + 10'(i);
      r[i*32 +: 32] = model_mem[a];
    end
    return r;
  endfunction

  // Counts init_done=0 samples from the reset edge through the sweep, then expects 1.
  task automatic count_sweep(input string tag);
    int zeros;
    int bad_valid;
    zeros = 0;
    bad_valid = 0;
    if (!bus.init_done) zeros++;
    for (int i = 0; i < 255; i++) begin
      step();
      if (!bus.init_done) zeros++;
      if (bus.rd1_valid || bus.rd0_valid) bad_valid++;
    end
    check({tag, "_init_low_cycles"}, 128'(zeros), 128'd256);
    step();
    check({tag, "_init_done_high"}, 128'(bus.init_done), 128'd1);
    check({tag, "_no_valid_in_init"}, 128'(bad_valid + int'(bus.rd1_valid)), 128'd0);
    model_clear();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_init_done"}, 128'(bus.init_done), 128'd0);
    check({tag, "_valids"}, 128'({bus.rd0_valid, bus.rd1_valid, bus.rd2_valid}), 128'd0);
    check({tag, "_rd0_data"}, bus.rd0_data, 128'd0);
    check({tag, "_rd12_data"}, 128'({bus.rd1_data, bus.rd2_data}), 128'd0);
  endtask

  task automatic fill_table();
    vec_t v;
    v = '0; v.wr1_addr = 10'h3FE; v.wr1_mask = 4'b1111; v.wr1_data = {WD, WC, WB, WA};
    vecs[0] = v;
    v = '0; v.rd0_en = 1'b1; v.rd0_addr = 10'h3FE; v.exp_rd0 = {WD, WC, WB, WA};
    v.rd1_en = 1'b1; v.rd1_addr = 10'h001; v.exp_rd1 = WD;
    v.rd2_en = 1'b1; v.rd2_addr = 10'h3FF; v.exp_rd2 = WB;
    vecs[1] = v;
    v = '0; v.wr1_addr = 10'h005; v.wr1_mask = 4'b0011; v.wr1_data = {32'hE7, 32'hE8, X6, X5};
    v.rd1_en = 1'b1; v.rd1_addr = 10'h005; v.exp_rd1 = BYPASS ? X5 : 32'h0;
    vecs[2] = v;
    v = '0; v.rd0_en = 1'b1; v.rd0_addr = 10'h005; v.exp_rd0 = {32'h0, 32'h0, X6, X5};
    v.rd1_en = 1'b1; v.rd1_addr = 10'h007; v.exp_rd1 = 32'h0;
    v.rd2_en = 1'b1; v.rd2_addr = 10'h008; v.exp_rd2 = 32'h0;
    vecs[3] = v;
    v = '0; v.wr0_en = 1'b1; v.wr0_addr = 10'h010; v.wr0_data = 32'h11111111;
    v.wr1_addr = 10'h00F; v.wr1_mask = 4'b0011; v.wr1_data = {64'h0, 32'h22222222, 32'h33333333};
    v.rd1_en = 1'b1; v.rd1_addr = 10'h010; v.exp_rd1 = BYPASS ? 32'h22222222 : 32'h0;
    vecs[4] = v;
    v = '0; v.rd1_en = 1'b1; v.rd1_addr = 10'h010; v.exp_rd1 = 32'h22222222;
    v.rd2_en = 1'b1; v.rd2_addr = 10'h00F; v.exp_rd2 = 32'h33333333;
    v.rd0_en = 1'b1; v.rd0_addr = 10'h00E; v.exp_rd0 = {32'h0, 32'h22222222, 32'h33333333, 32'h0};
    vecs[5] = v;
    v = '0; v.wr0_en = 1'b1; v.wr0_addr = 10'h020; v.wr0_data = 32'h55;
    v.rd1_en = 1'b1; v.rd1_addr = 10'h020; v.exp_rd1 = BYPASS ? 32'h55 : 32'h0;
    v.rd2_en = 1'b1; v.rd2_addr = 10'h020; v.exp_rd2 = BYPASS ? 32'h55 : 32'h0;
    vecs[6] = v;
    v = '0; v.rd1_en = 1'b1; v.rd1_addr = 10'h020; v.exp_rd1 = 32'h55;
    vecs[7] = v;
    v = '0; v.wr1_addr = 10'h3FF; v.wr1_mask = 4'b0011; v.wr1_data = {64'h0, 32'h77, 32'h66};
    v.wr0_en = 1'b1; v.wr0_addr = 10'h000; v.wr0_data = 32'h99;
    v.rd0_en = 1'b1; v.rd0_addr = 10'h3FF;
    v.exp_rd0 = BYPASS ? {32'h0, WD, 32'h77, 32'h66} : {32'h0, WD, WC, WB};
    vecs[8] = v;
    v = '0; v.rd0_en = 1'b1; v.rd0_addr = 10'h3FF; v.exp_rd0 = {32'h0, WD, 32'h77, 32'h66};
    v.rd1_en = 1'b1; v.rd1_addr = 10'h000; v.exp_rd1 = 32'h77;
    vecs[9] = v;
  endtask

  initial begin
    vec_t         v;
    logic [127:0] e0;
    logic [31:0]  e1, e2;
    checks = 0;
    failures = 0;
    idle_inputs();
    model_clear();
    fill_table();

    // Power-up reset and first sweep.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outputs_zero("reset");
    count_sweep("sweep0");
    bus.rd1_en = 1'b1; bus.rd1_addr = 10'h3A7;
    step();
    idle_inputs();
    check("rd1_3a7_valid", 128'(bus.rd1_valid), 128'd1);
    check("rd1_3a7_data", 128'(bus.rd1_data), 128'd0);

    // Directed vector table.
    for (int n = 0; n < 10; n++) begin
      apply_vec(vecs[n]);
      model_write(vecs[n]);
      step();
      idle_inputs();
      check($sformatf("vec%0d_valid", n),
            128'({bus.rd0_valid, bus.rd1_valid, bus.rd2_valid}),
            128'({vecs[n].rd0_en, vecs[n].rd1_en, vecs[n].rd2_en}));
      if (vecs[n].rd0_en) check($sformatf("vec%0d_rd0", n), bus.rd0_data, vecs[n].exp_rd0);
      if (vecs[n].rd1_en) check($sformatf("vec%0d_rd1", n), 128'(bus.rd1_data), 128'(vecs[n].exp_rd1));
      if (vecs[n].rd2_en) check($sformatf("vec%0d_rd2", n), 128'(bus.rd2_data), 128'(vecs[n].exp_rd2));
    end

    // Valid is a single-cycle pulse and data holds afterwards.
    step();
    check("hold_valid_low", 128'({bus.rd0_valid, bus.rd1_valid}), 128'd0);
    check("hold_rd0", bus.rd0_data, {32'h0, WD, 32'h77, 32'h66});
    check("hold_rd1", 128'(bus.rd1_data), 128'h77);

    // Randomized traffic, clustered around the wrap point to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      v = '0;
      v.wr0_en   = 1'($urandom_range(0, 1));
      v.wr0_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'h3F8 + 10'($urandom_range(0, 15));
      v.wr0_data = $urandom;
      case ($urandom_range(0, 4))
        0: v.wr1_mask = 4'b0000;
        1: v.wr1_mask = 4'b0001;
        2: v.wr1_mask = 4'b0011;
        3: v.wr1_mask = 4'b0111;
        default: v.wr1_mask = 4'b1111;
      endcase
      v.wr1_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'h3F8 + 10'($urandom_range(0, 15));
      v.wr1_data = {$urandom, $urandom, $urandom, $urandom};
      v.rd0_en   = 1'($urandom_range(0, 1));
      v.rd0_addr = 10'h3F8 + 10'($urandom_range(0, 15));
      v.rd1_en   = 1'($urandom_range(0, 1));
      v.rd1_addr = 10'h3F8 + 10'($urandom_range(0, 15));
      v.rd2_en   = 1'($urandom_range(0, 1));
      v.rd2_addr = 10'($urandom);
      if (BYPASS) model_write(v);
      e0 = model_wide(v.rd0_addr);
      e1 = model_mem[v.rd1_addr];
      e2 = model_mem[v.rd2_addr];
      if (!BYPASS) model_write(v);
      apply_vec(v);
      step();
      idle_inputs();
      check($sformatf("rnd%0d_valid", n),
            128'({bus.rd0_valid, bus.rd1_valid, bus.rd2_valid}),
            128'({v.rd0_en, v.rd1_en, v.rd2_en}));
      if (v.rd0_en) check($sformatf("rnd%0d_rd0", n), bus.rd0_data, e0);
      if (v.rd1_en) check($sformatf("rnd%0d_rd1", n), 128'(bus.rd1_data), 128'(e1));
      if (v.rd2_en) check($sformatf("rnd%0d_rd2", n), 128'(bus.rd2_data), 128'(e2));
    end

    // Make sure read registers carry non-zero data before the reset.
    bus.rd0_en = 1'b1; bus.rd0_addr = 10'h3FE;
    bus.rd1_en = 1'b1; bus.rd1_addr = 10'h001;
    step();
    idle_inputs();

    // Reset from RUN, then restart mid-sweep with a pre-init write pending.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outputs_zero("rst_from_run");
    bus.wr0_en = 1'b1; bus.wr0_addr = 10'h004; bus.wr0_data = 32'h00000BAD;
    bus.rd1_en = 1'b1; bus.rd1_addr = 10'h004;
    for (int i = 0; i < 100; i++) step();
    check("mid_init_still_low", 128'(bus.init_done), 128'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_sweep("sweep_mid");
    idle_inputs();
    bus.rd1_en = 1'b1; bus.rd1_addr = 10'h004;
    bus.rd0_en = 1'b1; bus.rd0_addr = 10'h3FE;
    step();
    idle_inputs();
    check("preinit_wr_discarded", 128'(bus.rd1_data), 128'd0);
    check("sweep_cleared_wide", bus.rd0_data, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
